// File: rtl/wvlt_cap_buf.sv
// Wavelet capture buffer: circular pre/post-trigger sample store with oldest-first readout.
// Arm, capture until the trigger plus POST samples, then freeze and drain one sample per pop.
module wvlt_cap_buf #(
   parameter int W     = 37,
   parameter int DEPTH = 12,
   parameter int POST  = 4
) (
   input  logic                         iclk,
   input  logic                         irst,
   input  logic                         iclk_ena,
   input  logic                         iena,
   input  logic signed [W-1:0]          idat,
   input  logic                         iarm,
   input  logic                         itrig,
   input  logic                         ird_req,
   output logic signed [W-1:0]          ord_dat,
   output logic                         ord_val,
   output logic [$clog2(DEPTH+1)-1:0]   ofill,
   output logic [1:0]                   ostate,
   output logic                         odone
);

   localparam int PW = $clog2(DEPTH);
   localparam int FW = $clog2(DEPTH+1);
   localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);
   localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

   if (W < 8 || W > 64) begin : g_bad_w
      $error("wvlt_cap_buf: W must be within 8..64");
   end
   if (DEPTH < 2 || DEPTH > 1024) begin : g_bad_depth
      $error("wvlt_cap_buf: DEPTH must be within 2..1024");
   end
   if (POST < 0 || POST > DEPTH - 1) begin : g_bad_post
      $error("wvlt_cap_buf: POST must be within 0..DEPTH-1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_POST = 2'd2,
      S_READ = 2'd3
   } state_t;

   state_t               state;
   state_t               state_d;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [FW-1:0]        fill;
   logic [PW-1:0]        post_cnt;
   logic                 samp;
   logic                 post_last;
   logic                 wr_en;
   logic                 pop_en;
   logic                 done_en;
   logic signed [W-1:0]  mem [DEPTH];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_P) ? '0 : p + PW'(1);
   endfunction

   // Oldest stored sample sits fill slots behind the write pointer, modulo DEPTH.
   function automatic logic [PW-1:0] ptr_oldest(input logic [PW-1:0] wp, input logic [FW-1:0] f);
      logic [FW:0] s;
      s = {{(FW-PW+1){1'b0}}, wp} + (FW+1)'(DEPTH) - {1'b0, f};
      if (s >= (FW+1)'(DEPTH))
         s = s - (FW+1)'(DEPTH);
      return PW'(s);
   endfunction

   assign samp      = iclk_ena & iena;
   assign post_last = (int'(post_cnt) == POST - 1);
   assign rd_ptr    = ptr_oldest(wr_ptr, fill);
   assign ofill     = fill;

   always_ff @(posedge iclk or posedge irst) begin
      if (irst)
         state <= S_IDLE;
      else
         state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (iarm) begin
         state_d = S_PRE;
      end else begin
         case (state)
            S_IDLE: state_d = S_IDLE;
            S_PRE:  if (itrig) state_d = (POST > 0) ? S_POST : S_READ;
            S_POST: if (samp && post_last) state_d = S_READ;
            S_READ: if (fill == '0 || (ird_req && fill == FW'(1))) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Arm overrides every other strobe in the cycle it is seen.
   always_comb begin
      ostate  = state;
      wr_en   = 1'b0;
      pop_en  = 1'b0;
      done_en = 1'b0;
      if (!iarm) begin
         case (state)
            S_PRE, S_POST: wr_en = samp;
            S_READ: begin
               pop_en  = ird_req && (fill != '0);
               done_en = (fill == '0) || (pop_en && fill == FW'(1));
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         wr_ptr   <= '0;
         fill     <= '0;
         post_cnt <= '0;
         ord_dat  <= '0;
         ord_val  <= 1'b0;
         odone    <= 1'b0;
      end else begin
         ord_val <= pop_en;
         odone   <= done_en;
         if (iarm) begin
            wr_ptr   <= '0;
            fill     <= '0;
            post_cnt <= '0;
         end else begin
            if (wr_en) begin
               wr_ptr <= ptr_inc(wr_ptr);
               if (fill != DEPTH_F)
                  fill <= fill + FW'(1);
               if (state == S_POST)
                  post_cnt <= post_cnt + PW'(1);
            end
            if (pop_en) begin
               ord_dat <= mem[rd_ptr];
               fill    <= fill - FW'(1);
            end
         end
      end
   end

   // Sample storage carries no reset; contents are meaningless until rewritten.
   always_ff @(posedge iclk) begin
      if (wr_en)
         mem[wr_ptr] <= idat;
   end

endmodule

// File: tb/tb_wvlt_cap_buf.sv
// Directed bench for wvlt_cap_buf: default build (DEPTH=12, POST=4) plus a POST=0 build.
module tb_wvlt_cap_buf;

   localparam int W = 37;

   logic iclk = 1'b0;
   always #5 iclk = ~iclk;

   logic irst = 1'b0, iclk_ena = 1'b0, iena = 1'b0, iarm = 1'b0, itrig = 1'b0, ird_req = 1'b0;
   logic signed [W-1:0] idat = '0;
   logic signed [W-1:0] ord_dat;
   logic                ord_val, odone;
   logic [3:0]          ofill;
   logic [1:0]          ostate;

   logic z_arm = 1'b0, z_trig = 1'b0, z_rd = 1'b0;
   logic signed [W-1:0] z_dat;
   logic                z_val, z_done;
   logic [3:0]          z_fill;
   logic [1:0]          z_state;

   int n_chk  = 0;
   int n_pass = 0;

   wvlt_cap_buf #(.W(W), .DEPTH(12), .POST(4)) dut (
      .iclk(iclk), .irst(irst), .iclk_ena(iclk_ena), .iena(iena), .idat(idat),
      .iarm(iarm), .itrig(itrig), .ird_req(ird_req),
      .ord_dat(ord_dat), .ord_val(ord_val), .ofill(ofill), .ostate(ostate), .odone(odone)
   );

   wvlt_cap_buf #(.W(W), .DEPTH(12), .POST(0)) dut_p0 (
      .iclk(iclk), .irst(irst), .iclk_ena(1'b0), .iena(1'b0), .idat(idat),
      .iarm(z_arm), .itrig(z_trig), .ird_req(z_rd),
      .ord_dat(z_dat), .ord_val(z_val), .ofill(z_fill), .ostate(z_state), .odone(z_done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic arm();
      iarm = 1'b1;
      tick();
      iarm = 1'b0;
   endtask

   task automatic push(input int v);
      iclk_ena = 1'b1;
      iena     = 1'b1;
      idat     = W'(v);
      tick();
      iclk_ena = 1'b0;
      iena     = 1'b0;
   endtask

   task automatic pop(input int v, input logic last);
      ird_req = 1'b1;
      tick();
      ird_req = 1'b0;
      chk("pop_val", 64'(ord_val), 64'd1);
      chk("pop_dat", 64'(ord_dat), 64'(v));
      chk("pop_done", 64'(odone), 64'(last));
   endtask

   initial begin
      // asynchronous reset, observed before any clock edge
      #2 irst = 1'b1;
      #2;
      chk("rst_state", 64'(ostate), 64'd0);
      chk("rst_fill", 64'(ofill), 64'd0);
      chk("rst_val", 64'(ord_val), 64'd0);
      chk("rst_done", 64'(odone), 64'd0);
      chk("rst_dat", 64'(ord_dat), 64'd0);
      tick();
      irst = 1'b0;
      tick();

      ird_req = 1'b1;
      tick();
      ird_req = 1'b0;
      chk("idle_rd_val", 64'(ord_val), 64'd0);

      // 20 samples, trigger after 16, 4 post samples -> 9..20
      arm();
      chk("arm_state", 64'(ostate), 64'd1);
      chk("arm_fill", 64'(ofill), 64'd0);
      for (int v = 1; v <= 16; v++) push(v);
      chk("pre_fill_sat", 64'(ofill), 64'd12);
      chk("pre_state", 64'(ostate), 64'd1);
      itrig = 1'b1;
      tick();
      itrig = 1'b0;
      chk("trig_state", 64'(ostate), 64'd2);
      for (int v = 17; v <= 19; v++) push(v);
      chk("post_state", 64'(ostate), 64'd2);
      push(20);
      chk("read_state", 64'(ostate), 64'd3);
      chk("read_fill", 64'(ofill), 64'd12);
      push(99);
      itrig = 1'b1;
      tick();
      itrig = 1'b0;
      chk("frozen_fill", 64'(ofill), 64'd12);
      chk("frozen_state", 64'(ostate), 64'd3);
      for (int v = 9; v <= 20; v++) pop(v, v == 20);
      chk("drain_state", 64'(ostate), 64'd0);
      chk("drain_fill", 64'(ofill), 64'd0);
      tick();
      chk("after_val", 64'(ord_val), 64'd0);
      chk("after_done", 64'(odone), 64'd0);
      chk("hold_dat", 64'(ord_dat), 64'd20);
      ird_req = 1'b1;
      tick();
      ird_req = 1'b0;
      chk("idle_rd2_val", 64'(ord_val), 64'd0);

      // negative values, unqualified samples
      arm();
      push(-5);
      push(7);
      push(-9);
      iclk_ena = 1'b0;
      iena     = 1'b1;
      idat     = W'(55);
      tick();
      chk("noclkena_fill", 64'(ofill), 64'd3);
      iclk_ena = 1'b1;
      iena     = 1'b0;
      tick();
      iclk_ena = 1'b0;
      chk("noena_fill", 64'(ofill), 64'd3);
      itrig = 1'b1;
      tick();
      itrig = 1'b0;
      chk("neg_trig_state", 64'(ostate), 64'd2);
      for (int v = 10; v <= 13; v++) push(v);
      chk("neg_state", 64'(ostate), 64'd3);
      chk("neg_fill", 64'(ofill), 64'd7);
      pop(-5, 1'b0);
      pop(7, 1'b0);
      pop(-9, 1'b0);
      for (int v = 10; v <= 13; v++) pop(v, v == 13);
      chk("neg_end_state", 64'(ostate), 64'd0);

      // trigger-cycle sample not counted, then abort readout with iarm+itrig+ird_req
      arm();
      for (int v = 1; v <= 12; v++) push(v);
      itrig = 1'b1;
      push(13);
      itrig = 1'b0;
      chk("trigsamp_state", 64'(ostate), 64'd2);
      chk("trigsamp_fill", 64'(ofill), 64'd12);
      for (int v = 14; v <= 16; v++) push(v);
      chk("post3_state", 64'(ostate), 64'd2);
      push(17);
      chk("post4_state", 64'(ostate), 64'd3);
      for (int v = 6; v <= 10; v++) pop(v, 1'b0);
      iarm    = 1'b1;
      itrig   = 1'b1;
      ird_req = 1'b1;
      tick();
      iarm    = 1'b0;
      itrig   = 1'b0;
      ird_req = 1'b0;
      chk("abort_state", 64'(ostate), 64'd1);
      chk("abort_fill", 64'(ofill), 64'd0);
      chk("abort_val", 64'(ord_val), 64'd0);
      chk("abort_done", 64'(odone), 64'd0);
      ird_req = 1'b1;
      tick();
      ird_req = 1'b0;
      chk("pre_rd_val", 64'(ord_val), 64'd0);
      chk("pre_rd_done", 64'(odone), 64'd0);

      // reset while in POST with 9 stored
      for (int v = 1; v <= 6; v++) push(v);
      itrig = 1'b1;
      tick();
      itrig = 1'b0;
      for (int v = 7; v <= 9; v++) push(v);
      chk("mid_state", 64'(ostate), 64'd2);
      chk("mid_fill", 64'(ofill), 64'd9);
      #2 irst = 1'b1;
      #1;
      chk("async_state", 64'(ostate), 64'd0);
      chk("async_fill", 64'(ofill), 64'd0);
      chk("async_dat", 64'(ord_dat), 64'd0);
      tick();
      irst    = 1'b0;
      ird_req = 1'b1;
      tick();
      tick();
      ird_req = 1'b0;
      chk("postrst_val", 64'(ord_val), 64'd0);
      chk("postrst_state", 64'(ostate), 64'd0);
      chk("postrst_fill", 64'(ofill), 64'd0);

      // POST=0 build: trigger on an empty buffer
      z_arm = 1'b1;
      tick();
      z_arm = 1'b0;
      chk("z_arm_state", 64'(z_state), 64'd1);
      z_rd   = 1'b1;
      z_trig = 1'b1;
      tick();
      z_trig = 1'b0;
      chk("z_read_state", 64'(z_state), 64'd3);
      chk("z_read_done", 64'(z_done), 64'd0);
      chk("z_read_val", 64'(z_val), 64'd0);
      tick();
      chk("z_done", 64'(z_done), 64'd1);
      chk("z_idle_state", 64'(z_state), 64'd0);
      chk("z_val", 64'(z_val), 64'd0);
      tick();
      z_rd = 1'b0;
      chk("z_done_end", 64'(z_done), 64'd0);
      chk("z_val_end", 64'(z_val), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/wvlt_cap_buf.md
WVLT_CAP_BUF -- requirements
Module: wvlt_cap_buf

Interface
REQ-001 Parameter W, default 37: sample width, signed; legal range 8..64.
REQ-002 Parameter DEPTH, default 12: capture depth in samples; legal range 2..1024; any integer, not only powers of two.
REQ-003 Parameter POST, default 4: samples captured after the trigger; legal range 0..DEPTH-1.
REQ-004 iclk  in  1  sole clock; all state changes on its rising edge.
REQ-005 irst  in  1  reset; asynchronous, active-high.
REQ-006 iclk_ena  in  1  sample-rate strobe from the wavelet core; qualifies iena/idat.
REQ-007 iena  in  1  sample valid; a sample is taken only when iclk_ena=1 and iena=1.
REQ-008 idat  in  W  signed sample data.
REQ-009 iarm  in  1  single-cycle pulse: start a new capture.
REQ-010 itrig  in  1  trigger level/pulse; used only in PRE.
REQ-011 ird_req  in  1  readout pop request, one sample per cycle.
REQ-012 ord_dat  out  W  readout data, registered.
REQ-013 ord_val  out  1  ord_dat valid, one-cycle pulse per pop.
REQ-014 ofill  out  clog2(DEPTH+1)  stored sample count.
REQ-015 ostate  out  2  state: 0 IDLE, 1 PRE, 2 POST, 3 READ.
REQ-016 odone  out  1  one-cycle pulse when the last sample is popped.

Function
REQ-017 Storage is a circular buffer of DEPTH words; wr_ptr wraps from DEPTH-1 to 0.
REQ-018 IDLE: no writes, no reads; iarm -> PRE with fill=0, wr_ptr=0, post_cnt=0.
REQ-019 PRE: every qualified sample is written at wr_ptr, wr_ptr advances, fill increments and saturates at DEPTH.
REQ-020 Once fill=DEPTH, each further write overwrites the oldest sample.
REQ-021 PRE with itrig=1 -> POST when POST>0, or -> READ when POST=0.
REQ-022 A qualified sample in the same cycle as the trigger is written; it is not counted in post_cnt.
REQ-023 POST: qualified samples are written as in PRE and post_cnt increments.
REQ-024 When the POST-th post-trigger sample is written, the state becomes READ in the same edge.
REQ-025 READ: buffer frozen; iclk_ena/iena/idat/itrig ignored.
REQ-026 Read pointer = (wr_ptr - fill) mod DEPTH, so samples come out oldest-first.
REQ-027 READ, ird_req=1 and fill>0: next cycle ord_val=1 with ord_dat = oldest sample; fill decrements.
REQ-028 ird_req with fill=0 or outside READ: ignored; ord_val=0; ord_dat holds its last value.
REQ-029 The pop that takes fill from 1 to 0 asserts odone together with that ord_val; the state becomes IDLE.
REQ-030 READ entered with fill=0 (trigger before any sample, POST=0): odone pulses next cycle, then -> IDLE.
REQ-031 iarm in any state restarts per REQ-018 and aborts any readout in progress; no odone.
REQ-032 iarm has priority over itrig and ird_req in the same cycle.
REQ-033 ofill and ostate are registered and reflect the state after each edge; latency from event to output is 1 cycle.

Reset
REQ-034 irst=1 asynchronously forces: state IDLE, wr_ptr=0, fill=0, post_cnt=0, ord_dat=0, ord_val=0, odone=0.
REQ-035 Buffer RAM contents are not reset and are don't-care after reset.
REQ-036 Reset asserted mid-capture or mid-readout discards all content; after release, nothing is output until a new iarm.

Verification (W=37, DEPTH=12, POST=4)
REQ-037 Arm, feed 20 qualified samples (values 1..20), trigger after sample 16 -> 4 more samples (17..20) captured; pops return 9..20 in order; odone with value 20.
REQ-038 Arm, feed 3 samples (-5, 7, -9), trigger, feed 4 samples (10..13) -> ofill=7; pops return -5, 7, -9, 10, 11, 12, 13; the sign of negative values is preserved across the full 37-bit width.
REQ-039 Samples with iena=1 but iclk_ena=0, and with iclk_ena=1 but iena=0, are never stored -> ofill unchanged.
REQ-040 Assert iarm during readout after 5 of 12 pops -> ostate=1, ofill=0, no odone, no further ord_val; assert itrig together with iarm -> trigger ignored.
REQ-041 Assert irst while in POST with ofill=9 -> outputs go to reset values immediately, without waiting for an iclk edge; ird_req is then ignored until a new iarm.
REQ-042 POST=0 build: trigger with fill=0 -> READ, one-cycle odone, then IDLE; ord_val stays 0.
